// File: rtl/rotation_counter.sv
// rotation_counter: modulo-MOD position counter for the encoder rotate stage.
// The programmable origin START is also the reset value. The counter steps up
// or down, supports a synchronous load, and counts full rotations back to
// START. When a non-zero rotation target is reached it pulses done for one
// cycle.
module rotation_counter #(
   parameter int MOD   = 5,
   parameter int WIDTH = 3,
   parameter int START = 3,
   parameter int ROT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             start,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [ROT_W-1:0] rot_target,
   output logic [WIDTH-1:0] out,
   output logic             co,
   output logic [ROT_W-1:0] rot_cnt,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] END_UP  = WIDTH'((START + MOD - 1) % MOD);
   localparam logic [WIDTH-1:0] END_DN  = WIDTH'((START + 1) % MOD);

   state_t           state, nxt_state;
   logic             step, wrap, final_wrap;
   logic [ROT_W:0]   rot_inc;
   logic [WIDTH-1:0] nxt_pos;

   // The last position before the origin, in the current direction.
   assign co = dir ? (out == END_DN) : (out == END_UP);

   // A step happens only in RUN, and only when neither clr nor load has
   // priority this cycle.
   assign step       = (state == S_RUN) && en && !clr && !load;
   assign wrap       = step && co;
   // The increment is one bit wider so that a saturated count can never
   // match the target a second time.
   assign rot_inc    = {1'b0, rot_cnt} + 1'b1;
   assign final_wrap = wrap && (rot_target != '0) && (rot_inc == {1'b0, rot_target});

   // Next position for one step, wrapping modulo MOD in both directions.
   always_comb begin
      nxt_pos = out;
      if (dir) nxt_pos = (out == '0)    ? MAX_V : out - 1'b1;
      else     nxt_pos = (out == MAX_V) ? '0    : out + 1'b1;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= nxt_state;
   end

   // Next-state decode. clr overrides everything; load blocks start; DONE always lasts one cycle.
   always_comb begin
      nxt_state = state;
      if (clr) nxt_state = S_IDLE;
      else begin
         case (state)
            S_IDLE:  if (start && !load) nxt_state = S_RUN;
            S_RUN:   if (final_wrap)     nxt_state = S_DONE;
            S_DONE:                      nxt_state = S_IDLE;
            default:                     nxt_state = S_IDLE;
         endcase
      end
   end

   // Status outputs decoded from the state.
   always_comb begin
      busy = (state == S_RUN);
      done = (state == S_DONE);
   end

   // Position, rotation count and sticky error, in priority order: clr > load > start > step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out     <= START_V;
         rot_cnt <= '0;
         err     <= 1'b0;
      end else if (clr) begin
         out     <= START_V;
         rot_cnt <= '0;
         err     <= 1'b0;
      end else if (load) begin
         if (load_val <= MAX_V) out <= load_val;
         else                   err <= 1'b1;
      end else if (start && state == S_IDLE) begin
         out     <= START_V;
         rot_cnt <= '0;
      end else if (step) begin
         out <= nxt_pos;
         if (wrap) rot_cnt <= rot_inc[ROT_W] ? rot_cnt : rot_inc[ROT_W-1:0];
      end
   end

endmodule

// File: tb/tb_rotation_counter.sv
// Bench for rotation_counter (MOD=5, START=3). The stimulus pushes a
// hand-computed expected output tuple for every cycle. A monitor pops each
// tuple and compares it with the DUT outputs. The monitor samples on the
// falling edge, or on an explicit event for asynchronous checks.
module tb_rotation_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clr = 1'b0, start = 1'b0, en = 1'b0, dir = 1'b0, load = 1'b0;
   logic [2:0] load_val = '0;
   logic [3:0] rot_target = '0;
   logic [2:0] out;
   logic       co, busy, done, err;
   logic [3:0] rot_cnt;

   typedef struct {
      string      nm;
      logic [2:0] o;
      logic       co;
      logic [3:0] rc;
      logic       b;
      logic       dn;
      logic       er;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   event mon_ev;

   rotation_counter #(.MOD(5), .WIDTH(3), .START(3), .ROT_W(4)) dut (
      .clk(clk), .rst(rst), .clr(clr), .start(start), .en(en), .dir(dir),
      .load(load), .load_val(load_val), .rot_target(rot_target),
      .out(out), .co(co), .rot_cnt(rot_cnt), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input string f, input int got, input int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s.%s got=%0d exp=%0d", nm, f, got, expv);
      end
   endtask

   // Monitor: consume every queued expectation when the DUT outputs are sampled.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or mon_ev);
         while (q.size() > 0) begin
            e = q.pop_front();
            chk(e.nm, "out",     int'(out),     int'(e.o));
            chk(e.nm, "co",      int'(co),      int'(e.co));
            chk(e.nm, "rot_cnt", int'(rot_cnt), int'(e.rc));
            chk(e.nm, "busy",    int'(busy),    int'(e.b));
            chk(e.nm, "done",    int'(done),    int'(e.dn));
            chk(e.nm, "err",     int'(err),     int'(e.er));
         end
      end
   end

   // Drive one cycle of inputs, then queue the outputs expected after the edge.
   task automatic cyc(input string nm, input logic c, s, e, d, l, input logic [2:0] lv,
                      input logic [2:0] o, input logic co_e, input logic [3:0] rc,
                      input logic b, dn, er);
      clr = c; start = s; en = e; dir = d; load = l; load_val = lv;
      @(posedge clk);
      #1;
      q.push_back('{nm, o, co_e, rc, b, dn, er});
      @(negedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values, checked while rst is still held
      rst = 1'b1;
      #1;
      q.push_back('{"reset", 3'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
      -> mon_ev;
      @(negedge clk); #1;
      rst = 1'b0;

      // up rotation, free-run: 3,4,0,1,2,3; co only at 2
      rot_target = 4'd0;
      //   name       clr st en dir ld lv     out  co  rc  busy done err
      cyc("up_start", 0, 1, 1, 0, 0, 3'd0, 3'd3, 0, 4'd0, 1, 0, 0);
      cyc("up_s1",    0, 0, 1, 0, 0, 3'd0, 3'd4, 0, 4'd0, 1, 0, 0);
      cyc("up_s2",    0, 0, 1, 0, 0, 3'd0, 3'd0, 0, 4'd0, 1, 0, 0);
      cyc("up_s3",    0, 0, 1, 0, 0, 3'd0, 3'd1, 0, 4'd0, 1, 0, 0);
      cyc("up_s4",    0, 0, 1, 0, 0, 3'd0, 3'd2, 1, 4'd0, 1, 0, 0);
      cyc("up_wrap",  0, 0, 1, 0, 0, 3'd0, 3'd3, 0, 4'd1, 1, 0, 0);

      // down rotation from a fresh run: 3,2,1,0,4,3; co only at 4
      cyc("dn_clr",   1, 0, 0, 1, 0, 3'd0, 3'd3, 0, 4'd0, 0, 0, 0);
      cyc("dn_start", 0, 1, 0, 1, 0, 3'd0, 3'd3, 0, 4'd0, 1, 0, 0);
      cyc("dn_s1",    0, 0, 1, 1, 0, 3'd0, 3'd2, 0, 4'd0, 1, 0, 0);
      cyc("dn_s2",    0, 0, 1, 1, 0, 3'd0, 3'd1, 0, 4'd0, 1, 0, 0);
      cyc("dn_s3",    0, 0, 1, 1, 0, 3'd0, 3'd0, 0, 4'd0, 1, 0, 0);
      cyc("dn_s4",    0, 0, 1, 1, 0, 3'd0, 3'd4, 1, 4'd0, 1, 0, 0);
      cyc("dn_wrap",  0, 0, 1, 1, 0, 3'd0, 3'd3, 0, 4'd1, 1, 0, 0);
      cyc("dn_hold",  0, 0, 0, 1, 0, 3'd0, 3'd3, 0, 4'd1, 1, 0, 0);

      // rot_target=2: done after 10 steps, one cycle only
      rot_target = 4'd2;
      cyc("tg_clr",   1, 0, 0, 0, 0, 3'd0, 3'd3, 0, 4'd0, 0, 0, 0);
      cyc("tg_start", 0, 1, 1, 0, 0, 3'd0, 3'd3, 0, 4'd0, 1, 0, 0);
      cyc("tg_s1",    0, 0, 1, 0, 0, 3'd0, 3'd4, 0, 4'd0, 1, 0, 0);
      cyc("tg_s2",    0, 0, 1, 0, 0, 3'd0, 3'd0, 0, 4'd0, 1, 0, 0);
      cyc("tg_s3",    0, 0, 1, 0, 0, 3'd0, 3'd1, 0, 4'd0, 1, 0, 0);
      cyc("tg_s4",    0, 0, 1, 0, 0, 3'd0, 3'd2, 1, 4'd0, 1, 0, 0);
      cyc("tg_s5",    0, 0, 1, 0, 0, 3'd0, 3'd3, 0, 4'd1, 1, 0, 0);
      cyc("tg_s6",    0, 0, 1, 0, 0, 3'd0, 3'd4, 0, 4'd1, 1, 0, 0);
      cyc("tg_s7",    0, 0, 1, 0, 0, 3'd0, 3'd0, 0, 4'd1, 1, 0, 0);
      cyc("tg_s8",    0, 0, 1, 0, 0, 3'd0, 3'd1, 0, 4'd1, 1, 0, 0);
      cyc("tg_s9",    0, 0, 1, 0, 0, 3'd0, 3'd2, 1, 4'd1, 1, 0, 0);
      cyc("tg_done",  0, 0, 1, 0, 0, 3'd0, 3'd3, 0, 4'd2, 0, 1, 0);
      cyc("tg_idle",  0, 0, 1, 0, 0, 3'd0, 3'd3, 0, 4'd2, 0, 0, 0);
      cyc("tg_idle2", 0, 0, 1, 0, 0, 3'd0, 3'd3, 0, 4'd2, 0, 0, 0);

      // load: illegal value sets err and holds out; legal load at co suppresses the wrap
      rot_target = 4'd0;
      cyc("ld_start", 0, 1, 0, 0, 0, 3'd0, 3'd3, 0, 4'd0, 1, 0, 0);
      cyc("ld_s1",    0, 0, 1, 0, 0, 3'd0, 3'd4, 0, 4'd0, 1, 0, 0);
      cyc("ld_s2",    0, 0, 1, 0, 0, 3'd0, 3'd0, 0, 4'd0, 1, 0, 0);
      cyc("ld_s3",    0, 0, 1, 0, 0, 3'd0, 3'd1, 0, 4'd0, 1, 0, 0);
      cyc("ld_s4",    0, 0, 1, 0, 0, 3'd0, 3'd2, 1, 4'd0, 1, 0, 0);
      cyc("ld_bad",   0, 0, 1, 0, 1, 3'd7, 3'd2, 1, 4'd0, 1, 0, 1);
      cyc("ld_ok",    0, 0, 1, 0, 1, 3'd1, 3'd1, 0, 4'd0, 1, 0, 1);
      cyc("ld_step",  0, 0, 1, 0, 0, 3'd0, 3'd2, 1, 4'd0, 1, 0, 1);

      // clr beats start and load in the same cycle, and clears err
      cyc("clr_all",  1, 1, 1, 0, 1, 3'd1, 3'd3, 0, 4'd0, 0, 0, 0);
      // load beats start in IDLE
      cyc("ld_vs_st", 0, 1, 0, 0, 1, 3'd0, 3'd0, 0, 4'd0, 0, 0, 0);

      // asynchronous reset mid-run at out=0, checked before the next clock
      cyc("rs_start", 0, 1, 0, 0, 0, 3'd0, 3'd3, 0, 4'd0, 1, 0, 0);
      cyc("rs_s1",    0, 0, 1, 0, 0, 3'd0, 3'd4, 0, 4'd0, 1, 0, 0);
      cyc("rs_s2",    0, 0, 1, 0, 0, 3'd0, 3'd0, 0, 4'd0, 1, 0, 0);
      rst = 1'b1;
      #1;
      q.push_back('{"rst_async", 3'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
      -> mon_ev;
      @(negedge clk); #1;
      rst = 1'b0;
      cyc("post_rst", 0, 1, 0, 0, 0, 3'd0, 3'd3, 0, 4'd0, 1, 0, 0);

      // every queued expectation must have been consumed
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d exp=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
